// File: rtl/shutdown_sequencer.sv
// Orders per-domain enables down (highest index first) and up (ascending), waiting on each power-good ack then settling.
// Request edge to first enable change: 1 cycle; per stage at least 1 + SETTLE cycles; an ack timeout latches FAULT until rst.
module shutdown_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int TIMEOUT    = 1000,
    parameter int SETTLE     = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shutdown_req,
    input  logic                  wake_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [2:0]            fault_stage,
    output logic [2:0]            cur_stage
);

    localparam logic [2:0] ST_ON          = 3'd0;
    localparam logic [2:0] ST_DOWN_WAIT   = 3'd1;
    localparam logic [2:0] ST_DOWN_SETTLE = 3'd2;
    localparam logic [2:0] ST_OFF         = 3'd3;
    localparam logic [2:0] ST_UP_WAIT     = 3'd4;
    localparam logic [2:0] ST_UP_SETTLE   = 3'd5;
    localparam logic [2:0] ST_FAULT       = 3'd6;

    localparam logic [2:0]       TOP_STAGE   = 3'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_END  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic [NUM_STAGES-1:0] en_q, en_d;
    logic [2:0]            cur_q, cur_d;
    logic [2:0]            fstage_q, fstage_d;
    logic                  shut_hist_q, wake_hist_q;
    logic                  shut_edge, wake_edge;
    logic                  ack_cur;

    function automatic logic [NUM_STAGES-1:0] stage_mask(input logic [2:0] idx);
        logic [NUM_STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx == 3'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

    assign shut_edge = shutdown_req & ~shut_hist_q;
    assign wake_edge = wake_req & ~wake_hist_q;
    assign ack_cur   = |(stage_ack & stage_mask(cur_q));

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        en_d     = en_q;
        cur_d    = cur_q;
        fstage_d = fstage_q;
        case (state_q)
            ST_ON: begin
                if (shut_edge) begin
                    en_d    = en_q & ~stage_mask(TOP_STAGE);
                    cur_d   = TOP_STAGE;
                    timer_d = '0;
                    state_d = ST_DOWN_WAIT;
                end
            end
            ST_DOWN_WAIT: begin
                // Ack observed on the same cycle as the timeout wins.
                if (!ack_cur) begin
                    timer_d = '0;
                    state_d = ST_DOWN_SETTLE;
                end else if (timer_q == TIMEOUT_END) begin
                    fstage_d = cur_q;
                    state_d  = ST_FAULT;
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
            end
            ST_DOWN_SETTLE: begin
                if (timer_q == SETTLE_END) begin
                    timer_d = '0;
                    if (cur_q == 3'd0) begin
                        state_d = ST_OFF;
                    end else begin
                        cur_d   = cur_q - 3'd1;
                        en_d    = en_q & ~stage_mask(cur_q - 3'd1);
                        state_d = ST_DOWN_WAIT;
                    end
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
            end
            ST_OFF: begin
                if (wake_edge) begin
                    en_d    = en_q | stage_mask(3'd0);
                    cur_d   = 3'd0;
                    timer_d = '0;
                    state_d = ST_UP_WAIT;
                end
            end
            ST_UP_WAIT: begin
                if (ack_cur) begin
                    timer_d = '0;
                    state_d = ST_UP_SETTLE;
                end else if (timer_q == TIMEOUT_END) begin
                    fstage_d = cur_q;
                    state_d  = ST_FAULT;
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
            end
            ST_UP_SETTLE: begin
                if (timer_q == SETTLE_END) begin
                    timer_d = '0;
                    if (cur_q == TOP_STAGE) begin
                        state_d = ST_ON;
                    end else begin
                        cur_d   = cur_q + 3'd1;
                        en_d    = en_q | stage_mask(cur_q + 3'd1);
                        state_d = ST_UP_WAIT;
                    end
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_ON;
            end
        endcase
    end

    // Edge history resets high so a request already asserted at reset release must toggle first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ON;
            timer_q     <= '0;
            en_q        <= '1;
            cur_q       <= 3'd0;
            fstage_q    <= 3'd0;
            shut_hist_q <= 1'b1;
            wake_hist_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            en_q        <= en_d;
            cur_q       <= cur_d;
            fstage_q    <= fstage_d;
            shut_hist_q <= shutdown_req;
            wake_hist_q <= wake_req;
        end
    end

    assign stage_en    = en_q;
    assign busy        = (state_q == ST_DOWN_WAIT) || (state_q == ST_DOWN_SETTLE) ||
                         (state_q == ST_UP_WAIT)   || (state_q == ST_UP_SETTLE);
    assign done        = (state_q == ST_OFF);
    assign fault       = (state_q == ST_FAULT);
    assign fault_stage = fstage_q;
    assign cur_stage   = cur_q;

endmodule
